// File: rtl/hci_core_memmap_demux_outstanding.sv
// ---------------------------------------------------------------------------
// hci_core_memmap_demux_outstanding
//
// Address-map demultiplexer: routes one HCI core initiator to NB_REGION
// memory-mapped targets with up to NB_OUTSTND transactions in flight.
// Addresses that hit no enabled region go to an internal error responder,
// which answers one cycle after the grant. Responses come back in issue
// order because a request to a target other than the one currently in
// flight is held off until every outstanding response has returned.
//
// Ports
//   clk_i, rst_ni, clear_i      clock, async active-low reset, sync clear
//   region_start_addr_i         per-region inclusive base address
//   region_end_addr_i           per-region exclusive limit address
//   region_en_i                 per-region enable
//   slave_*                     initiator side (req/gnt/add/wen/data/be/
//                               boffs/lrdy in, r_data/r_opc/r_valid out)
//   master_*                    target side, one lane per region
//   err_o                       one-cycle pulse with every error response
//   busy_o                      at least one transaction outstanding
// ---------------------------------------------------------------------------
module hci_core_memmap_demux_outstanding #(
  parameter int unsigned NB_REGION  = 2,
  parameter int unsigned AW         = 32,
  parameter int unsigned AWC        = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned BOW        = 16,
  parameter int unsigned NB_OUTSTND = 4,
  parameter logic [31:0] ERR_RDATA  = 32'hBADACCE5
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic [NB_REGION-1:0][AW-1:0]     region_start_addr_i,
  input  logic [NB_REGION-1:0][AW-1:0]     region_end_addr_i,
  input  logic [NB_REGION-1:0]             region_en_i,
  // initiator side
  input  logic                             slave_req_i,
  output logic                             slave_gnt_o,
  input  logic [AW-1:0]                    slave_add_i,
  input  logic                             slave_wen_i,
  input  logic [DW-1:0]                    slave_data_i,
  input  logic [DW/8-1:0]                  slave_be_i,
  input  logic [BOW-1:0]                   slave_boffs_i,
  input  logic                             slave_lrdy_i,
  output logic [DW-1:0]                    slave_r_data_o,
  output logic                             slave_r_opc_o,
  output logic                             slave_r_valid_o,
  // target side
  output logic [NB_REGION-1:0]             master_req_o,
  input  logic [NB_REGION-1:0]             master_gnt_i,
  output logic [NB_REGION-1:0][AW-1:0]     master_add_o,
  output logic [NB_REGION-1:0]             master_wen_o,
  output logic [NB_REGION-1:0][DW-1:0]     master_data_o,
  output logic [NB_REGION-1:0][DW/8-1:0]   master_be_o,
  output logic [NB_REGION-1:0][BOW-1:0]    master_boffs_o,
  output logic [NB_REGION-1:0]             master_lrdy_o,
  input  logic [NB_REGION-1:0][DW-1:0]     master_r_data_i,
  input  logic [NB_REGION-1:0]             master_r_opc_i,
  input  logic [NB_REGION-1:0]             master_r_valid_i,
  // status
  output logic                             err_o,
  output logic                             busy_o
);

  localparam int unsigned TW = $clog2(NB_REGION + 1);
  localparam int unsigned CW = $clog2(NB_OUTSTND + 1);
  localparam logic [TW-1:0] ERR_IDX = TW'(NB_REGION);
  localparam logic [CW-1:0] CNT_MAX = CW'(NB_OUTSTND);

  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_cur;
  logic          r_err_pend;

  logic [NB_REGION-1:0]          w_hit;
  logic [TW-1:0]                 w_dst;
  logic                          w_is_err;
  logic                          w_cnt_nz;
  logic                          w_stall;
  logic                          w_en;
  logic                          w_tgt_gnt;
  logic                          w_issue;
  logic [NB_REGION-1:0][AWC-1:0] w_off;
  logic                          w_rsp_valid;
  logic [DW-1:0]                 w_rsp_data;
  logic                          w_rsp_opc;
  logic                          w_rvalid;
  logic                          w_rsp_vis;

  // -------------------------------------------------------------------------
  // Address decode: unsigned full-width compare, lowest hitting index wins.
  // -------------------------------------------------------------------------
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NB_REGION; i++) begin
      w_hit[i] = region_en_i[i] &&
                 (slave_add_i >= region_start_addr_i[i]) &&
                 (slave_add_i <  region_end_addr_i[i]);
    end
  end

  // Scanning from the top down lets the lowest hit overwrite the others.
  always_comb begin
    w_dst = ERR_IDX;
    for (int unsigned i = NB_REGION; i > 0; i--) begin
      if (w_hit[i-1]) w_dst = TW'(i - 1);
    end
  end

  assign w_is_err = (w_dst == ERR_IDX);
  assign w_cnt_nz = (r_cnt != '0);

  // Stall on a full counter (regardless of a response popping this cycle)
  // or on a target change while anything is still outstanding.
  assign w_stall = (r_cnt == CNT_MAX) || (w_cnt_nz && (w_dst != r_cur));

  // Nothing is requested or granted while reset or clear is applied.
  assign w_en = rst_ni && !clear_i;

  always_comb begin
    w_tgt_gnt = 1'b1;
    for (int unsigned i = 0; i < NB_REGION; i++) begin
      if (w_dst == TW'(i)) w_tgt_gnt = master_gnt_i[i];
    end
  end

  assign slave_gnt_o = w_en && !w_stall && w_tgt_gnt;
  assign w_issue     = slave_req_i && slave_gnt_o;

  // -------------------------------------------------------------------------
  // Forwarding: requests to the selected lane, payload broadcast to all.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < NB_REGION; i++) begin
      w_off[i]          = slave_add_i[AWC-1:0] - region_start_addr_i[i][AWC-1:0];
      master_add_o[i]   = AW'(w_off[i]);
      master_req_o[i]   = w_en && slave_req_i && (w_dst == TW'(i)) && !w_stall;
      master_wen_o[i]   = slave_wen_i;
      master_data_o[i]  = slave_data_i;
      master_be_o[i]    = slave_be_i;
      master_boffs_o[i] = slave_boffs_i;
      master_lrdy_o[i]  = slave_lrdy_i;
    end
  end

  // -------------------------------------------------------------------------
  // Response path: select the lane of the target currently in flight.
  // -------------------------------------------------------------------------
  always_comb begin
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;
    w_rsp_opc   = 1'b0;
    if (r_cur == ERR_IDX) begin
      w_rsp_valid = r_err_pend;
      w_rsp_data  = DW'(ERR_RDATA);
      w_rsp_opc   = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NB_REGION; i++) begin
        if (r_cur == TW'(i)) begin
          w_rsp_valid = master_r_valid_i[i];
          w_rsp_data  = master_r_data_i[i];
          w_rsp_opc   = master_r_opc_i[i];
        end
      end
    end
  end

  // With nothing outstanding the response lane is ignored entirely, which
  // drops stray or stale target responses after a reset or clear.
  assign w_rsp_vis = w_cnt_nz && !clear_i;
  assign w_rvalid  = w_rsp_vis && w_rsp_valid;

  assign slave_r_valid_o = w_rvalid;
  assign slave_r_data_o  = w_rsp_vis ? w_rsp_data : '0;
  assign slave_r_opc_o   = w_rsp_vis ? w_rsp_opc  : 1'b0;
  assign err_o           = w_rvalid && (r_cur == ERR_IDX);
  assign busy_o          = w_cnt_nz;

  // -------------------------------------------------------------------------
  // State: outstanding counter, current target, pending error response.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_cur      <= '0;
      r_err_pend <= 1'b0;
    end else if (clear_i) begin
      r_cnt      <= '0;
      r_cur      <= '0;
      r_err_pend <= 1'b0;
    end else begin
      if (w_issue) r_cur <= w_dst;
      r_err_pend <= w_issue && w_is_err;
      if (w_issue && !w_rvalid) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_issue && w_rvalid) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_cnt <= CNT_MAX);

  a_no_issue_when_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_issue && w_stall));

endmodule
